stump_control_fsm: RTL

- Multi-cycle control sequencer for the Stump datapath: steps FETCH -> EXECUTE -> (MEMORY) and decodes the instruction register into datapath controls.
- Drives the CE of the 4-bit condition-code register and consumes that register's Q output for branch condition evaluation.
- Sits between the instruction register/memory interface and the datapath register bank, ALU and flag register.

---
 rtl/stump_ctrl_pkg.sv | 57 +++++
 rtl/stump_cond_eval.sv | 45 ++++
 rtl/stump_control_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// stump_ctrl_pkg : shared encodings for the Stump control sequencer
// Rev 1.0
// ============================================================================
package stump_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_fetch   = 2'b00;
  localparam state_t c_st_execute = 2'b01;
  localparam state_t c_st_memory  = 2'b10;
  localparam state_t c_st_illegal = 2'b11;

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_adc  = 3'b001;
  localparam logic [2:0] c_op_sub  = 3'b010;
  localparam logic [2:0] c_op_sbc  = 3'b011;
  localparam logic [2:0] c_op_and  = 3'b100;
  localparam logic [2:0] c_op_or   = 3'b101;
  localparam logic [2:0] c_op_ldst = 3'b110;
  localparam logic [2:0] c_op_bcc  = 3'b111;

  localparam logic [3:0] c_cond_al = 4'h0;
  localparam logic [3:0] c_cond_nv = 4'h1;
  localparam logic [3:0] c_cond_hi = 4'h2;
  localparam logic [3:0] c_cond_ls = 4'h3;
  localparam logic [3:0] c_cond_cc = 4'h4;
  localparam logic [3:0] c_cond_cs = 4'h5;
  localparam logic [3:0] c_cond_ne = 4'h6;
  localparam logic [3:0] c_cond_eq = 4'h7;
  localparam logic [3:0] c_cond_vc = 4'h8;
  localparam logic [3:0] c_cond_vs = 4'h9;
  localparam logic [3:0] c_cond_pl = 4'hA;
  localparam logic [3:0] c_cond_mi = 4'hB;
  localparam logic [3:0] c_cond_ge = 4'hC;
  localparam logic [3:0] c_cond_lt = 4'hD;
  localparam logic [3:0] c_cond_gt = 4'hE;
  localparam logic [3:0] c_cond_le = 4'hF;

  localparam int c_cc_n = 3;
  localparam int c_cc_z = 2;
  localparam int c_cc_v = 1;
  localparam int c_cc_c = 0;

  function automatic logic is_alu_op(input logic [2:0] op);
    logic r;
    case (op)
      c_op_add, c_op_adc, c_op_sub,
      c_op_sbc, c_op_and, c_op_or:  r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stump_cond_eval.sv
`default_nettype none
// ============================================================================
// stump_cond_eval : evaluates a 4-bit branch condition against the N/Z/V/C flags
// Rev 1.0
// ============================================================================
module stump_cond_eval
  import stump_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       cond_true
);

  logic w_n, w_z, w_v, w_c;

  assign w_n = cc[c_cc_n];
  assign w_z = cc[c_cc_z];
  assign w_v = cc[c_cc_v];
  assign w_c = cc[c_cc_c];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      c_cond_al: cond_true = 1'b1;
      c_cond_nv: cond_true = 1'b0;
      c_cond_hi: cond_true = ~w_c & ~w_z;
      c_cond_ls: cond_true = w_c | w_z;
      c_cond_cc: cond_true = ~w_c;
      c_cond_cs: cond_true = w_c;
      c_cond_ne: cond_true = ~w_z;
      c_cond_eq: cond_true = w_z;
      c_cond_vc: cond_true = ~w_v;
      c_cond_vs: cond_true = w_v;
      c_cond_pl: cond_true = ~w_n;
      c_cond_mi: cond_true = w_n;
      c_cond_ge: cond_true = w_n ~^ w_v;
      c_cond_lt: cond_true = w_n ^ w_v;
      c_cond_gt: cond_true = ~w_z & (w_n ~^ w_v);
      c_cond_le: cond_true = w_z | (w_n ^ w_v);
      default:   cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stump_control_fsm.sv
`default_nettype none
// ============================================================================
// stump_control_fsm : FETCH/EXECUTE/MEMORY sequencer and instruction decoder
// Rev 1.0
// ============================================================================
module stump_control_fsm
  import stump_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = 2'b00,
  parameter logic [2:0] PC_REG      = 3'd7
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
  input  logic        mem_ready,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        ir_en,
  output logic        pc_inc,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic        opB_sel,
  output logic        ext_op,
  output logic [2:0]  alu_func,
  output logic [1:0]  shift_op,
  output logic        cc_en,
  output logic        addr_en,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        branch_taken
);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_op;
  logic       w_imm;
  logic       w_sbit;
  logic       w_cond_true;

  assign w_op   = ir[15:13];
  assign w_imm  = ir[12];
  assign w_sbit = ir[11];

  stump_cond_eval u_cond_eval (
    .cond      (ir[11:8]),
    .cc        (cc),
    .cond_true (w_cond_true)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= RESET_STATE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    fetch        = 1'b0;
    execute      = 1'b0;
    memory       = 1'b0;
    ir_en        = 1'b0;
    pc_inc       = 1'b0;
    reg_write    = 1'b0;
    dest         = 3'd0;
    srcA         = 3'd0;
    srcB         = 3'd0;
    opB_sel      = 1'b0;
    ext_op       = 1'b0;
    alu_func     = 3'd0;
    shift_op     = 2'd0;
    cc_en        = 1'b0;
    addr_en      = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    branch_taken = 1'b0;

    // Reset overrides everything so no write strobe can glitch while RST is high.
    if (RST) begin
      fetch   = 1'b1;
      mem_ren = 1'b1;
    end else begin
      case (r_state)
        c_st_fetch: begin
          fetch   = 1'b1;
          mem_ren = 1'b1;
          if (mem_ready) begin
            ir_en        = 1'b1;
            pc_inc       = 1'b1;
            w_next_state = c_st_execute;
          end
        end

        c_st_execute: begin
          execute      = 1'b1;
          w_next_state = c_st_fetch;
          if (is_alu_op(w_op)) begin
            reg_write = 1'b1;
            dest      = ir[10:8];
            srcA      = ir[7:5];
            srcB      = ir[4:2];
            opB_sel   = w_imm;
            alu_func  = w_op;
            shift_op  = w_imm ? 2'b00 : ir[1:0];
            cc_en     = w_sbit;
          end else if (w_op == c_op_ldst) begin
            srcA         = ir[7:5];
            opB_sel      = w_imm;
            addr_en      = 1'b1;
            w_next_state = c_st_memory;
          end else if (w_op == c_op_bcc) begin
            // Branch target = PC + sign-extended 8-bit offset, written back to PC.
            srcA         = PC_REG;
            dest         = PC_REG;
            opB_sel      = 1'b1;
            ext_op       = 1'b1;
            branch_taken = w_cond_true;
            reg_write    = w_cond_true;
          end
        end

        c_st_memory: begin
          memory = 1'b1;
          if (w_sbit) begin
            mem_wen = 1'b1;
            srcB    = ir[10:8];
          end else begin
            mem_ren = 1'b1;
            if (mem_ready) begin
              reg_write = 1'b1;
              dest      = ir[10:8];
            end
          end
          if (mem_ready) w_next_state = c_st_fetch;
        end

        // Illegal encoding presents as FETCH but never loads IR; it recovers next edge.
        c_st_illegal: begin
          fetch        = 1'b1;
          mem_ren      = 1'b1;
          w_next_state = c_st_fetch;
        end

        default: w_next_state = c_st_fetch;
      endcase
    end
  end

endmodule
`default_nettype wire
